// File: rtl/id_stage_if.sv
// Bundle between fetch/control/writeback logic and the decode stage.
// The master side drives instructions, pipeline control and writeback; the slave is the stage.
interface id_stage_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       instr_in;
    logic              instr_valid;
    logic              instr_ready;
    logic              stall;
    logic              flush;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic [5:0]        ex_op;
    logic [4:0]        ex_dst;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic              ex_is_imm;
    logic              ex_illegal;

    modport master (
        output instr_in, instr_valid, stall, flush, wb_en, wb_addr, wb_data,
        input  instr_ready, ex_valid, ex_op, ex_dst, ex_a, ex_b, ex_is_imm, ex_illegal
    );

    modport slave (
        input  instr_in, instr_valid, stall, flush, wb_en, wb_addr, wb_data,
        output instr_ready, ex_valid, ex_op, ex_dst, ex_a, ex_b, ex_is_imm, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode stage: opcode classification, 32x32 register file with
// same-cycle writeback bypass, and a stallable/flushable ID/EX register.
module id_stage #(
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1
) (
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);

    logic [DATA_W-1:0] rf [32];

    logic [5:0]        op;
    logic [4:0]        dst;
    logic [4:0]        rs_a;
    logic [4:0]        rs_b;
    logic              is_r;
    logic              is_i;
    logic              illegal;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] opnd_b;
    logic              wb_live;

    assign op      = bus.instr_in[31:26];
    assign dst     = bus.instr_in[25:21];
    assign rs_a    = bus.instr_in[20:16];
    assign rs_b    = bus.instr_in[15:11];
    assign is_r    = (op[5:3] == 3'b010);
    assign is_i    = (op[5:3] == 3'b011);
    assign illegal = ~(is_r | is_i);
    assign imm_ext = {{(DATA_W-16){bus.instr_in[15]}}, bus.instr_in[15:0]};

    assign bus.instr_ready = ~bus.stall;

    // A write to r0 is dead when r0 is hardwired, so it must neither land nor bypass.
    assign wb_live = bus.wb_en && !((ZERO_REG != 0) && (bus.wb_addr == 5'd0));

    always_comb begin
        rd_a = rf[rs_a];
        if ((ZERO_REG != 0) && (rs_a == 5'd0)) begin
            rd_a = '0;
        end else if (wb_live && (bus.wb_addr == rs_a)) begin
            rd_a = bus.wb_data;
        end
    end

    always_comb begin
        rd_b = rf[rs_b];
        if ((ZERO_REG != 0) && (rs_b == 5'd0)) begin
            rd_b = '0;
        end else if (wb_live && (bus.wb_addr == rs_b)) begin
            rd_b = bus.wb_data;
        end
    end

    assign opnd_b = is_i ? imm_ext : rd_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_live) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Flush beats stall; an unstalled edge loads the decode even for bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_op      <= '0;
            bus.ex_dst     <= '0;
            bus.ex_a       <= '0;
            bus.ex_b       <= '0;
            bus.ex_is_imm  <= 1'b0;
            bus.ex_illegal <= 1'b0;
        end else if (bus.flush) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_op      <= '0;
            bus.ex_dst     <= '0;
            bus.ex_a       <= '0;
            bus.ex_b       <= '0;
            bus.ex_is_imm  <= 1'b0;
            bus.ex_illegal <= 1'b0;
        end else if (!bus.stall) begin
            bus.ex_valid   <= bus.instr_valid;
            bus.ex_op      <= op;
            bus.ex_dst     <= dst;
            bus.ex_a       <= rd_a;
            bus.ex_b       <= opnd_b;
            bus.ex_is_imm  <= is_i;
            bus.ex_illegal <= illegal;
        end
    end

endmodule
